shim_write_control: RTL and testbench

SHIM_WRITE_CONTROL -- requirements
Module: shim_write_control

---
 rtl/shim_pkg.sv | 32 +++
 rtl/shim_write_control_if.sv | 31 +++
 rtl/shim_blk_classify.sv | 21 ++
 rtl/shim_write_control.sv | 208 ++++++++++++++++++++
 tb/tb_shim_write_control.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shim_pkg.sv
// Shared definitions for the shim write path.
//   - Sync-header codes for 66-bit blocks (data / control).
//   - Control-block type codes that open a packet.
//   - TERM_MIN: any control type above this value closes a packet.
//   - ERR_TERM_D: payload of the error terminate block. It is written in place of a
//     block that cannot be accepted, so the packet already queued is still closed.
//   - Write-side FSM state type.
package shim_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  localparam logic [7:0] START_TYPE_0 = 8'h78;
  localparam logic [7:0] START_TYPE_1 = 8'h33;
  localparam logic [7:0] START_TYPE_2 = 8'h66;

  localparam logic [7:0] TERM_MIN = 8'h86;

  localparam logic [63:0] ERR_TERM_D = 64'h1E1E1E1E_1E1E1E87;

  typedef enum logic [1:0] {
    StIdle,
    StPkt,
    StDrop
  } wr_state_e;

  function automatic logic is_start_type(input logic [7:0] blk_type);
    return (blk_type == START_TYPE_0) || (blk_type == START_TYPE_1) ||
           (blk_type == START_TYPE_2);
  endfunction

endpackage

// File: rtl/shim_write_control_if.sv
// Block stream and shim-queue signals for the shim write controller.
//   rx_valid / rx_c / rx_d        : incoming block strobe, sync header, payload
//   shimq_read                    : dequeue strobe from the read controller
//   shim_outc / shim_outd         : block currently at the queue head
//   shimq_write / shim_inc / shim_ind : enqueue port into the shim queue
// Modports: master = block source and queue model, slave = write controller.
interface shim_write_control_if;

  logic        rx_valid;
  logic [1:0]  rx_c;
  logic [63:0] rx_d;

  logic        shimq_read;
  logic [1:0]  shim_outc;
  logic [63:0] shim_outd;

  logic        shimq_write;
  logic [1:0]  shim_inc;
  logic [63:0] shim_ind;

  modport master (
    output rx_valid, rx_c, rx_d, shimq_read, shim_outc, shim_outd,
    input  shimq_write, shim_inc, shim_ind
  );

  modport slave (
    input  rx_valid, rx_c, rx_d, shimq_read, shim_outc, shim_outd,
    output shimq_write, shim_inc, shim_ind
  );

endinterface

// File: rtl/shim_blk_classify.sv
// Combinational block classifier.
//   c        : sync header
//   d        : block type byte (payload bits [7:0]; no other payload bit affects the class)
//   is_start : control block whose type opens a packet
//   is_term  : control block whose type is above TERM_MIN
module shim_blk_classify
  import shim_pkg::*;
(
  input  logic [1:0] c,
  input  logic [7:0] d,
  output logic       is_start,
  output logic       is_term
);

  logic is_ctrl;

  assign is_ctrl  = (c == SYNC_CTRL);
  assign is_start = is_ctrl && is_start_type(d);
  assign is_term  = is_ctrl && (d > TERM_MIN);

endmodule

// File: rtl/shim_write_control.sv
// Shim queue write controller.
// Admits whole packets into the shim queue only when enough space is free. When a packet
// cannot complete, it is closed with an error terminate block so the read side never waits
// on an unterminated packet.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (release synchronised to clk)
//   bus          : block input, queue head, and enqueue port (slave modport)
//   occupancy    : blocks held in the queue (0..DEPTH)
//   pkt_avail    : at least one complete packet is buffered
//   overflow     : sticky; a packet was cut because the queue filled
//   drop_cnt     : packets dropped or truncated (saturating)
//   pkt_cnt      : terminate blocks written (saturating)
// Build option: define SHIM_WR_STATS_EN to build drop_cnt/pkt_cnt. Without it, both are
// tied to zero.
module shim_write_control
  import shim_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned MIN_FREE = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  shim_write_control_if.slave    bus,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   pkt_avail,
  output logic                   overflow,
  output logic [15:0]            drop_cnt,
  output logic [15:0]            pkt_cnt
);

  localparam int unsigned OccW  = $clog2(DEPTH) + 1;
  localparam int unsigned FreeW = OccW + 1;

  logic             rst_sync_q;
  wr_state_e        state_q;
  logic             wr_q;
  logic             term_wr_q;
  logic [1:0]       inc_q;
  logic [63:0]      ind_q;
  logic             ovf_q;
  logic             avail_q;
  logic [OccW-1:0]  occ_q, occ_d;
  logic [OccW-1:0]  buf_q, buf_d;
  logic [FreeW-1:0] committed;
  logic [FreeW-1:0] free;

  logic in_start, in_term;
  logic head_start, head_term;
  logic rx_fire, rd_ok, admit, fits;
  logic buf_inc, buf_dec;

  shim_blk_classify u_in_classify (
    .c        (bus.rx_c),
    .d        (bus.rx_d[7:0]),
    .is_start (in_start),
    .is_term  (in_term)
  );

  shim_blk_classify u_head_classify (
    .c        (bus.shim_outc),
    .d        (bus.shim_outd[7:0]),
    .is_start (head_start),
    .is_term  (head_term)
  );

  // Blocks are ignored until the edge after reset release has been seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 1'b0;
    end else begin
      rst_sync_q <= 1'b1;
    end
  end

  // A write issued this cycle is not in occupancy yet but already owns a slot.
  assign committed = FreeW'(occ_q) + FreeW'(wr_q);
  assign free      = FreeW'(DEPTH) - committed;

  assign rx_fire = bus.rx_valid && rst_sync_q;
  assign rd_ok   = bus.shimq_read && (occ_q != '0);
  assign admit   = (free >= FreeW'(MIN_FREE));
  // A terminate block may take the last slot. Any other block must leave one slot free,
  // so the packet can still be closed with an error terminate.
  assign fits    = in_term ? (free != '0) : (free >= FreeW'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wr_q      <= 1'b0;
      term_wr_q <= 1'b0;
      inc_q     <= '0;
      ind_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_q      <= 1'b0;
      term_wr_q <= 1'b0;
      if (rx_fire) begin
        unique case (state_q)
          StIdle: begin
            if (in_start) begin
              if (admit) begin
                wr_q    <= 1'b1;
                inc_q   <= bus.rx_c;
                ind_q   <= bus.rx_d;
                state_q <= StPkt;
              end else begin
                state_q <= StDrop;
              end
            end
          end
          StPkt: begin
            if (in_start) begin
              // Close the open packet. The new packet's blocks are discarded.
              if (free != '0) begin
                wr_q      <= 1'b1;
                term_wr_q <= 1'b1;
                inc_q     <= SYNC_CTRL;
                ind_q     <= ERR_TERM_D;
              end
              state_q <= StIdle;
            end else if (fits) begin
              wr_q      <= 1'b1;
              term_wr_q <= in_term;
              inc_q     <= bus.rx_c;
              ind_q     <= bus.rx_d;
              if (in_term) begin
                state_q <= StIdle;
              end
            end else begin
              ovf_q <= 1'b1;
              if (free != '0) begin
                wr_q      <= 1'b1;
                term_wr_q <= 1'b1;
                inc_q     <= SYNC_CTRL;
                ind_q     <= ERR_TERM_D;
              end
              state_q <= in_term ? StIdle : StDrop;
            end
          end
          StDrop: begin
            if (in_term) begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign occ_d = occ_q + OccW'(wr_q) - OccW'(rd_ok);

  // Start and terminate type codes are disjoint, so a head block is never both.
  assign buf_inc = wr_q && term_wr_q;
  assign buf_dec = rd_ok && head_term && !head_start && (buf_q != '0);
  assign buf_d   = buf_q + OccW'(buf_inc) - OccW'(buf_dec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q   <= '0;
      buf_q   <= '0;
      avail_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      buf_q   <= buf_d;
      avail_q <= (buf_d != '0);
    end
  end

  assign bus.shimq_write = wr_q;
  assign bus.shim_inc    = inc_q;
  assign bus.shim_ind    = ind_q;
  assign occupancy       = occ_q;
  assign pkt_avail       = avail_q;
  assign overflow        = ovf_q;

`ifdef SHIM_WR_STATS_EN
  logic        drop_evt;
  logic [15:0] drop_q;
  logic [15:0] pktc_q;

  // Refused starts, starts that cut an open packet, and packets truncated for lack of space.
  assign drop_evt = rx_fire &&
                    (((state_q == StIdle) && in_start && !admit) ||
                     ((state_q == StPkt) && (in_start || !fits)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
      pktc_q <= '0;
    end else begin
      if (drop_evt && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
      if (buf_inc && (pktc_q != 16'hFFFF)) begin
        pktc_q <= pktc_q + 16'd1;
      end
    end
  end

  assign drop_cnt = drop_q;
  assign pkt_cnt  = pktc_q;
`else
  assign drop_cnt = '0;
  assign pkt_cnt  = '0;
`endif

endmodule

// File: tb/tb_shim_write_control.sv
// Directed bench for shim_write_control (DEPTH=64, MIN_FREE=16).
// It models the external shim queue so that the head block and reads are driven from
// the blocks the DUT has written.
module tb_shim_write_control;

  localparam logic [1:0]  CT   = 2'b01;
  localparam logic [1:0]  DT   = 2'b10;
  localparam logic [63:0] S78  = 64'h1111_2222_3333_4478;
  localparam logic [63:0] S33  = 64'h5555_6666_7777_8833;
  localparam logic [63:0] S66  = 64'h9999_AAAA_BBBB_CC66;
  localparam logic [63:0] D1   = 64'hD1D1_0000_0000_0011;
  localparam logic [63:0] D2   = 64'hD2D2_0000_0000_0022;
  localparam logic [63:0] D3   = 64'hD3D3_0000_0000_0033;
  localparam logic [63:0] DS   = 64'h0000_0000_0000_0078;
  localparam logic [63:0] T87  = 64'h0000_0000_0000_0087;
  localparam logic [63:0] O1E  = 64'h0000_0000_0000_001E;
  localparam logic [63:0] O86  = 64'h0000_0000_0000_0086;
  localparam logic [63:0] ERR  = 64'h1E1E1E1E_1E1E1E87;
`ifdef SHIM_WR_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  occupancy;
  logic        pkt_avail, overflow;
  logic [15:0] drop_cnt, pkt_cnt;

  shim_write_control_if bus ();

  shim_write_control #(
    .DEPTH    (64),
    .MIN_FREE (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .occupancy (occupancy),
    .pkt_avail (pkt_avail),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .pkt_cnt   (pkt_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned n_wr  = 0;
  logic [65:0] last_wr;
  logic [65:0] q[$];

  typedef struct {
    logic        v;
    logic [1:0]  c;
    logic [63:0] d;
    logic        w;
    logic [1:0]  ec;
    logic [63:0] ed;
    int unsigned occ;
    logic        av;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic drive_head();
    if (q.size() != 0) begin
      bus.shim_outc = q[0][65:64];
      bus.shim_outd = q[0][63:0];
    end else begin
      bus.shim_outc = 2'b00;
      bus.shim_outd = '0;
    end
  endtask

  // One clock: the queue model takes the write/read seen before the edge.
  task automatic tick();
    logic        w;
    logic        r;
    logic [65:0] blk;
    w   = bus.shimq_write;
    blk = {bus.shim_inc, bus.shim_ind};
    r   = bus.shimq_read && (q.size() != 0);
    @(posedge clk);
    #1;
    if (r) void'(q.pop_front());
    if (w) begin
      q.push_back(blk);
      n_wr++;
      last_wr = blk;
    end
    drive_head();
  endtask

  task automatic send(input logic [1:0] c, input logic [63:0] d);
    bus.rx_valid = 1'b1;
    bus.rx_c     = c;
    bus.rx_d     = d;
    tick();
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.rx_valid   = 1'b0;
    bus.rx_c       = '0;
    bus.rx_d       = '0;
    bus.shimq_read = 1'b0;
    q.delete();
    drive_head();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic fill_pkt(input int n_data);
    send(CT, S78);
    for (int k = 0; k < n_data; k++) send(DT, D1);
    send(CT, T87);
    idle(2);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned base;

    tbl[0]  = '{1'b1, CT, S78, 1'b1, CT, S78, 0, 1'b0};
    tbl[1]  = '{1'b1, DT, D1,  1'b1, DT, D1,  1, 1'b0};
    tbl[2]  = '{1'b1, DT, D2,  1'b1, DT, D2,  2, 1'b0};
    tbl[3]  = '{1'b1, DT, D3,  1'b1, DT, D3,  3, 1'b0};
    tbl[4]  = '{1'b1, CT, T87, 1'b1, CT, T87, 4, 1'b0};
    tbl[5]  = '{1'b0, DT, D1,  1'b0, CT, T87, 5, 1'b1};
    tbl[6]  = '{1'b1, DT, DS,  1'b0, CT, T87, 5, 1'b1};
    tbl[7]  = '{1'b1, CT, O1E, 1'b0, CT, T87, 5, 1'b1};
    tbl[8]  = '{1'b1, CT, O86, 1'b0, CT, T87, 5, 1'b1};
    tbl[9]  = '{1'b1, CT, S33, 1'b1, CT, S33, 5, 1'b1};
    tbl[10] = '{1'b1, DT, D2,  1'b1, DT, D2,  6, 1'b1};
    tbl[11] = '{1'b1, CT, S66, 1'b1, CT, ERR, 7, 1'b1};
    tbl[12] = '{1'b1, DT, D3,  1'b0, CT, ERR, 8, 1'b1};
    tbl[13] = '{1'b1, CT, T87, 1'b0, CT, ERR, 8, 1'b1};

    // Reset state
    do_reset();
    check("rst.write", 64'(bus.shimq_write), 64'd0);
    check("rst.inc", 64'(bus.shim_inc), 64'd0);
    check("rst.ind", bus.shim_ind, 64'd0);
    check("rst.occ", 64'(occupancy), 64'd0);
    check("rst.avail", 64'(pkt_avail), 64'd0);
    check("rst.ovf", 64'(overflow), 64'd0);
    check("rst.drop", 64'(drop_cnt), 64'd0);
    check("rst.pktcnt", 64'(pkt_cnt), 64'd0);

    // A read with an empty queue is ignored.
    bus.shimq_read = 1'b1;
    tick();
    bus.shimq_read = 1'b0;
    check("empty_read.occ", 64'(occupancy), 64'd0);

    // Basic packet, discarded blocks while idle, and a start cutting an open packet
    for (int i = 0; i < 14; i++) begin
      bus.rx_valid = tbl[i].v;
      bus.rx_c     = tbl[i].c;
      bus.rx_d     = tbl[i].d;
      tick();
      check($sformatf("row%0d.write", i), 64'(bus.shimq_write), 64'(tbl[i].w));
      check($sformatf("row%0d.inc", i), 64'(bus.shim_inc), 64'(tbl[i].ec));
      check($sformatf("row%0d.ind", i), bus.shim_ind, tbl[i].ed);
      check($sformatf("row%0d.occ", i), 64'(occupancy), 64'(tbl[i].occ));
      check($sformatf("row%0d.avail", i), 64'(pkt_avail), 64'(tbl[i].av));
    end
    bus.rx_valid = 1'b0;

    // Drain up to the error terminate; one buffered packet remains.
    bus.shimq_read = 1'b1;
    repeat (7) tick();
    bus.shimq_read = 1'b0;
    check("drain.occ", 64'(occupancy), 64'd1);
    check("drain.avail", 64'(pkt_avail), 64'd1);
    // A term write and a term read on the same edge leave both counts unchanged.
    send(CT, S78);
    send(CT, T87);
    bus.rx_valid   = 1'b0;
    bus.shimq_read = 1'b1;
    tick();
    bus.shimq_read = 1'b0;
    check("simul.occ", 64'(occupancy), 64'd2);
    check("simul.avail", 64'(pkt_avail), 64'd1);
    check("simul.drop", 64'(drop_cnt), Stats ? 64'd1 : 64'd0);
    check("simul.pktcnt", 64'(pkt_cnt), Stats ? 64'd3 : 64'd0);
    bus.shimq_read = 1'b1;
    repeat (2) tick();
    check("simul_drain.occ", 64'(occupancy), 64'd0);
    check("simul_drain.avail", 64'(pkt_avail), 64'd0);
    tick();
    bus.shimq_read = 1'b0;
    check("underflow.occ", 64'(occupancy), 64'd0);
    check("underflow.avail", 64'(pkt_avail), 64'd0);

    // Start refused with only 14 blocks free
    do_reset();
    fill_pkt(48);
    check("fill50.occ", 64'(occupancy), 64'd50);
    base = n_wr;
    send(CT, S78);
    send(DT, D1);
    send(DT, D2);
    send(CT, T87);
    send(DT, D3);
    idle(2);
    check("refuse.writes", 64'(n_wr - base), 64'd0);
    check("refuse.occ", 64'(occupancy), 64'd50);
    check("refuse.drop", 64'(drop_cnt), Stats ? 64'd1 : 64'd0);
    check("refuse.ovf", 64'(overflow), 64'd0);

    // Start admitted with exactly MIN_FREE free, then truncated by an error terminate
    do_reset();
    fill_pkt(46);
    check("fill48.occ", 64'(occupancy), 64'd48);
    base = n_wr;
    send(CT, S66);
    for (int k = 0; k < 20; k++) send(DT, D2);
    idle(2);
    check("trunc.writes", 64'(n_wr - base), 64'd16);
    check("trunc.last", last_wr[63:0], ERR);
    check("trunc.lastc", 64'(last_wr[65:64]), 64'(CT));
    check("trunc.ovf", 64'(overflow), 64'd1);
    check("trunc.occ", 64'(occupancy), 64'd64);
    check("trunc.avail", 64'(pkt_avail), 64'd1);
    check("trunc.drop", 64'(drop_cnt), Stats ? 64'd1 : 64'd0);
    check("trunc.pktcnt", 64'(pkt_cnt), Stats ? 64'd2 : 64'd0);
    base = n_wr;
    send(CT, T87);
    send(CT, S78);
    idle(2);
    check("full.writes", 64'(n_wr - base), 64'd0);
    check("full.drop", 64'(drop_cnt), Stats ? 64'd2 : 64'd0);
    check("full.occ", 64'(occupancy), 64'd64);

    // Reset asserted mid-packet
    do_reset();
    send(CT, S78);
    send(DT, D1);
    bus.rx_valid = 1'b1;
    bus.rx_c     = DT;
    bus.rx_d     = D2;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.write", 64'(bus.shimq_write), 64'd0);
    check("midrst.ind", bus.shim_ind, 64'd0);
    check("midrst.occ", 64'(occupancy), 64'd0);
    bus.rx_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    drive_head();
    base = n_wr;
    send(DT, D1);
    send(DT, D2);
    send(CT, T87);
    idle(1);
    check("postrst.writes", 64'(n_wr - base), 64'd0);
    send(CT, S33);
    check("postrst.write", 64'(bus.shimq_write), 64'd1);
    check("postrst.ind", bus.shim_ind, S33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
